dac_ds_mix: RTL and testbench

Multi-channel audio mixer with delta-sigma 1-bit DAC output. Each channel has its own gain. The summed sample is scaled by a master volume and saturated, then fed to a delta-sigma modulator clocked on `clk`. It sits at the mapper audio output, mixing expansion-audio sources into the single cartridge sound pin. Sample capture is paced by the CPU M2 clock, synchronised into `clk`.

---
 rtl/dac_mix_pkg.sv | 24 ++
 rtl/dac_ds_mod.sv | 64 ++++++
 rtl/dac_ds_mix.sv | 170 +++++++++++++++++
 tb/tb_dac_ds_mix.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_mix_pkg.sv
// dac_mix_pkg: shared definitions for the dac_ds_mix audio mixer.
//   - dm_state_e   : sample-pipeline FSM states
//   - MASTER_UNITY : master-volume code that represents a gain of 1.0
//   - acc_width()  : width of the channel accumulator
package dac_mix_pkg;

    typedef enum logic [2:0] {
        DM_IDLE  = 3'd0,
        DM_SNAP  = 3'd1,
        DM_ACC   = 3'd2,
        DM_SCALE = 3'd3,
        DM_LOAD  = 3'd4
    } dm_state_e;

    localparam logic [7:0] MASTER_UNITY = 8'd128;

    // Each channel contributes at most ~2x full scale (gain < 2.0), so one
    // extra bit per channel plus log2(channels) bits for the sum.
    function automatic int unsigned acc_width(input int unsigned depth,
                                              input int unsigned channels);
        return depth + 1 + $clog2(channels);
    endfunction

endpackage

// File: rtl/dac_ds_mod.sv
// dac_ds_mod: delta-sigma 1-bit DAC modulator, updated every clk.
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   vol_mul in  DEPTH-bit unsigned mixed sample
//   snd     out 1-bit DAC output (inverted polarity), 1 while in reset
// Build option: define DAC_MIX_DS2_EN for the second-order modulator;
// the default build uses the first-order modulator.
module dac_ds_mod #(
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] vol_mul,
    output logic             snd
);

    logic r_snd;

`ifdef DAC_MIX_DS2_EN
    localparam int unsigned S_W = DEPTH + 3;
    localparam logic [S_W-1:0] FB_FULL = {3'b001, {DEPTH{1'b0}}};

    logic [S_W-1:0] r_s1, r_s2;
    logic [S_W-1:0] w_fb;
    logic [S_W-1:0] w_vol_ext;

    assign w_fb      = r_s2[S_W-1] ? '0 : FB_FULL;
    assign w_vol_ext = {3'b000, vol_mul};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_snd <= 1'b1;
        end else begin
            r_s1  <= r_s1 + w_vol_ext - w_fb;
            r_s2  <= r_s2 + r_s1 - w_fb;
            r_snd <= r_s2[S_W-1];
        end
    end
`else
    localparam int unsigned S_W = DEPTH + 2;

    logic [S_W-1:0] r_s;
    logic [S_W-1:0] w_delta;

    // When s is "negative" the sign-extension term subtracts 2^DEPTH,
    // giving the feedback of a classic first-order loop.
    assign w_delta = {2'b00, vol_mul} + {r_s[S_W-1], r_s[S_W-1], {DEPTH{1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s   <= '0;
            r_snd <= 1'b1;
        end else begin
            r_s   <= r_s + w_delta;
            r_snd <= ~r_s[S_W-1];
        end
    end
`endif

    assign snd = r_snd;

endmodule

// File: rtl/dac_ds_mix.sv
// dac_ds_mix: multi-channel audio mixer feeding a delta-sigma 1-bit DAC.
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   m2         in  CPU M2, asynchronous; paces sample capture (1 per 2 periods)
//   ch_vol     in  packed channel samples, channel i at [i*DEPTH +: DEPTH]
//   ch_gain    in  packed per-channel gains, 1 << (GAIN_W-1) is unity
//   master_vol in  master gain, 128 is unity
//   mute       in  forces a zero mixed sample
//   clip_clr   in  clears clip and ovr (a simultaneous set wins)
//   clip       out sticky: mixed sample saturated
//   ovr        out sticky: a tick arrived while a sample was in progress
//   snd        out 1-bit DAC output
// Build option: DAC_MIX_DS2_EN selects the second-order modulator inside
// dac_ds_mod.
module dac_ds_mix
    import dac_mix_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned GAIN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m2,
    input  logic [CHANNELS*DEPTH-1:0]  ch_vol,
    input  logic [CHANNELS*GAIN_W-1:0] ch_gain,
    input  logic [7:0]                 master_vol,
    input  logic                       mute,
    input  logic                       clip_clr,
    output logic                       clip,
    output logic                       ovr,
    output logic                       snd
);

    localparam int unsigned ACC_W  = acc_width(DEPTH, CHANNELS);
    localparam int unsigned PROD_W = ACC_W + 1;
    localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned MSHIFT = $clog2(MASTER_UNITY);

    // M2 synchroniser and tick generation
    logic r_m2_s1, r_m2_s2, r_m2_d, r_phase;
    logic w_fall, w_tick;

    // FSM and datapath
    dm_state_e                 r_state, w_state_nxt;
    logic [CHANNELS*DEPTH-1:0]  r_vol_snap;
    logic [CHANNELS*GAIN_W-1:0] r_gain_snap;
    logic [7:0]                 r_master_snap;
    logic                       r_mute_snap;
    logic [IDX_W-1:0]           r_idx;
    logic [ACC_W-1:0]           r_acc;
    logic [PROD_W-1:0]          r_prod;
    logic [DEPTH-1:0]           r_vol_mul;
    logic                       r_clip, r_ovr;

    logic [DEPTH-1:0]           w_vol_sel;
    logic [GAIN_W-1:0]          w_gain_sel;
    logic [DEPTH+GAIN_W-1:0]    w_term_full;
    logic [ACC_W+7:0]           w_scaled_full;
    logic [DEPTH-1:0]           w_sat;
    logic                       w_last, w_over, w_clip_set, w_ovr_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m2_s1 <= 1'b0;
            r_m2_s2 <= 1'b0;
            r_m2_d  <= 1'b0;
            r_phase <= 1'b0;
        end else begin
            r_m2_s1 <= m2;
            r_m2_s2 <= r_m2_s1;
            r_m2_d  <= r_m2_s2;
            if (w_fall) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign w_fall = r_m2_d & ~r_m2_s2;
    assign w_tick = w_fall & r_phase;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DM_IDLE:  if (w_tick) w_state_nxt = DM_SNAP;
            DM_SNAP:  w_state_nxt = DM_ACC;
            DM_ACC:   if (w_last) w_state_nxt = DM_SCALE;
            DM_SCALE: w_state_nxt = DM_LOAD;
            DM_LOAD:  w_state_nxt = DM_IDLE;
            default:  w_state_nxt = DM_IDLE;
        endcase
    end

    always_comb begin
        w_vol_sel  = '0;
        w_gain_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_vol_sel  = r_vol_snap[i*DEPTH +: DEPTH];
                w_gain_sel = r_gain_snap[i*GAIN_W +: GAIN_W];
            end
        end
    end

    assign w_last        = (r_idx == IDX_W'(CHANNELS - 1));
    assign w_term_full   = {{GAIN_W{1'b0}}, w_vol_sel} * {{DEPTH{1'b0}}, w_gain_sel};
    assign w_scaled_full = {8'd0, r_acc} * {{ACC_W{1'b0}}, r_master_snap};
    assign w_over        = |r_prod[PROD_W-1:DEPTH];
    assign w_sat         = w_over ? {DEPTH{1'b1}} : r_prod[DEPTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= DM_IDLE;
            r_vol_snap    <= '0;
            r_gain_snap   <= '0;
            r_master_snap <= '0;
            r_mute_snap   <= 1'b0;
            r_idx         <= '0;
            r_acc         <= '0;
            r_prod        <= '0;
            r_vol_mul     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                DM_SNAP: begin
                    r_vol_snap    <= ch_vol;
                    r_gain_snap   <= ch_gain;
                    r_master_snap <= master_vol;
                    r_mute_snap   <= mute;
                    r_acc         <= '0;
                    r_idx         <= '0;
                end
                DM_ACC: begin
                    r_acc <= r_acc + ACC_W'(w_term_full >> (GAIN_W - 1));
                    r_idx <= r_idx + IDX_W'(1);
                end
                DM_SCALE: r_prod <= PROD_W'(w_scaled_full >> MSHIFT);
                DM_LOAD:  r_vol_mul <= r_mute_snap ? '0 : w_sat;
                default: ;
            endcase
        end
    end

    // Saturation is only evaluated when the sample is not muted.
    assign w_clip_set = (r_state == DM_LOAD) && !r_mute_snap && w_over;
    assign w_ovr_set  = w_tick && (r_state != DM_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clip <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_clip <= w_clip_set | (r_clip & ~clip_clr);
            r_ovr  <= w_ovr_set | (r_ovr & ~clip_clr);
        end
    end

    assign clip = r_clip;
    assign ovr  = r_ovr;

    dac_ds_mod #(
        .DEPTH (DEPTH)
    ) u_mod (
        .clk     (clk),
        .rst     (rst),
        .vol_mul (r_vol_mul),
        .snd     (snd)
    );

endmodule

// File: tb/tb_dac_ds_mix.sv
module tb_dac_ds_mix;
    import dac_mix_pkg::*;

    localparam int unsigned CH    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned GW    = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                m2  = 1'b1;
    logic [CH*DEPTH-1:0] ch_vol = '0;
    logic [CH*GW-1:0]    ch_gain = '0;
    logic [7:0]          master_vol = 8'd128;
    logic                mute = 1'b0;
    logic                clip_clr = 1'b0;
    logic                clip, ovr, snd;

    dac_ds_mix #(
        .CHANNELS (CH),
        .DEPTH    (DEPTH),
        .GAIN_W   (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m2         (m2),
        .ch_vol     (ch_vol),
        .ch_gain    (ch_gain),
        .master_vol (master_vol),
        .mute       (mute),
        .clip_clr   (clip_clr),
        .clip       (clip),
        .ovr        (ovr),
        .snd        (snd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vol;
        logic        clp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic load_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a LOAD cycle means a new mixed sample appears on the next edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (load_pending) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sample: got 0x%0h, expected no sample", dut.r_vol_mul);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_vol"}, 32'(dut.r_vol_mul), 32'(e.vol));
                check({e.name, "_clip"}, 32'(clip), 32'(e.clp));
            end
        end
        load_pending = rst && (dut.r_state == DM_LOAD);
    end

    task automatic push_exp(input logic [15:0] v, input logic c, input string name);
        exp_t e;
        e.vol  = v;
        e.clp  = c;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic set_all(input logic [15:0] v0, input logic [7:0] g0,
                           input logic [15:0] v1, input logic [7:0] g1,
                           input logic [15:0] v2, input logic [7:0] g2,
                           input logic [15:0] v3, input logic [7:0] g3);
        ch_vol  = {v3, v2, v1, v0};
        ch_gain = {g3, g2, g1, g0};
    endtask

    // Two slow M2 falling edges = exactly one tick (phase returns to 0).
    // With finish=0 it returns right after the second fall, m2 left low.
    task automatic do_tick(input bit finish);
        m2 = 1'b0;
        repeat (6) @(negedge clk);
        m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2 = 1'b0;
        if (finish) begin
            repeat (6) @(negedge clk);
            m2 = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_state(input dm_state_e st, input string name);
        for (int i = 0; i < 40 && dut.r_state != st; i++) @(negedge clk);
        check({name, "_reached"}, 32'(dut.r_state == st), 32'd1);
    endtask

    task automatic pulse_clr();
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
    endtask

    // M2 period of 2 clk: ticks 4 clk apart, the second one lands in ACC.
    task automatic run_overrun(input string name);
        set_all(16'h3000, 8'd128, 16'h0, 8'd0, 16'h0, 8'd0, 16'h0, 8'd0);
        master_vol = 8'd128;
        push_exp(16'h3000, 1'b0, name);
        @(negedge clk);
        repeat (4) begin
            m2 = 1'b0;
            @(negedge clk);
            m2 = 1'b1;
            @(negedge clk);
        end
        set_all(16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255);
        wait_drain(name);
        check({name, "_ovr"}, 32'(ovr), 32'd1);
    endtask

    initial begin
        int bad;
        int ones;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_snd", 32'(snd), 32'd1);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_vol_mul", 32'(dut.r_vol_mul), 32'd0);
        rst = 1'b1;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (snd !== 1'b1 || clip !== 1'b0 || ovr !== 1'b0) bad++;
        end
        check("zero_input_hold_bad_cycles", 32'(bad), 32'd0);

        // Single channel at half scale, unity gains
        set_all(16'h8000, 8'd128, 16'h0, 8'd0, 16'h0, 8'd0, 16'h0, 8'd0);
        master_vol = 8'd128;
        push_exp(16'h8000, 1'b0, "single");
        do_tick(1);
        wait_drain("single");
        repeat (20) @(negedge clk);
        ones = 0;
        repeat (65536) begin
            @(negedge clk);
            ones += int'(snd);
        end
        n_tests++;
        if (ones < 32767 || ones > 32769) begin
            n_fail++;
            $display("FAIL duty_half: got %0d ones, expected 32768 +/- 1", ones);
        end

        // Saturation, then clear and re-saturate
        set_all(16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255);
        master_vol = 8'd255;
        push_exp(16'hFFFF, 1'b1, "sat");
        do_tick(1);
        wait_drain("sat");
        check("sat_ovr", 32'(ovr), 32'd0);
        pulse_clr();
        check("clip_cleared", 32'(clip), 32'd0);
        push_exp(16'hFFFF, 1'b1, "sat2");
        do_tick(1);
        wait_drain("sat2");
        pulse_clr();
        check("clip_cleared2", 32'(clip), 32'd0);

        // Mixed gains and master: 0x4000 + 0x7F80 + 2 + 0 = 49026, *96>>7 = 0x8FA1
        set_all(16'h4000, 8'd128, 16'h4000, 8'd255, 16'h0100, 8'd1, 16'hFFFF, 8'd0);
        master_vol = 8'd96;
        push_exp(16'h8FA1, 1'b0, "mixed");
        do_tick(1);
        wait_drain("mixed");

        // Mute is snapshotted; releasing it after SNAP changes nothing
        set_all(16'h1234, 8'd128, 16'h0, 8'd0, 16'h0, 8'd0, 16'h0, 8'd0);
        master_vol = 8'd128;
        mute = 1'b1;
        push_exp(16'h0000, 1'b0, "mute");
        do_tick(0);
        wait_state(DM_SNAP, "mute_snap");
        @(negedge clk);
        mute = 1'b0;
        set_all(16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255);
        m2 = 1'b1;
        wait_drain("mute");

        // Input changes after SNAP: 0x1000 + (0x2000*64>>7) = 0x2000
        set_all(16'h1000, 8'd128, 16'h2000, 8'd64, 16'h0, 8'd0, 16'h0, 8'd0);
        master_vol = 8'd128;
        push_exp(16'h2000, 1'b0, "snapshot");
        do_tick(0);
        wait_state(DM_SNAP, "snapshot_snap");
        @(negedge clk);
        set_all(16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255, 16'hFFFF, 8'd255);
        master_vol = 8'd255;
        m2 = 1'b1;
        wait_drain("snapshot");

        // Overrun keeps the in-flight sample intact
        run_overrun("ovr1");

        // Reset in the middle of ACC
        set_all(16'h3000, 8'd128, 16'h0, 8'd0, 16'h0, 8'd0, 16'h0, 8'd0);
        do_tick(0);
        wait_state(DM_ACC, "mid_acc");
        check("ovr_before_rst", 32'(ovr), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_snd", 32'(snd), 32'd1);
        check("midrst_clip", 32'(clip), 32'd0);
        check("midrst_ovr", 32'(ovr), 32'd0);
        check("midrst_vol_mul", 32'(dut.r_vol_mul), 32'd0);
        check("midrst_acc", 32'(dut.r_acc), 32'd0);
        check("midrst_state", 32'(dut.r_state), 32'(DM_IDLE));
        repeat (3) @(negedge clk);
        m2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Recovery after reset, and clip_clr also clears ovr
        run_overrun("ovr2");
        pulse_clr();
        check("ovr_cleared", 32'(ovr), 32'd0);
        set_all(16'h0800, 8'd128, 16'h0, 8'd0, 16'h0, 8'd0, 16'h0, 8'd0);
        push_exp(16'h0800, 1'b0, "post_rst");
        do_tick(1);
        wait_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
